button_conditioner: RTL

//  Turns one raw push-button pin (e.g. btnC/btnU) into clean, clk-synchronous strobes.

---
 rtl/button_conditioner.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Raw push-button to clean level plus one-cycle press/release strobes: 2-FF sync, counter debounce, 4-state FSM.
// Optional auto-repeat of btn_pulse while held is built only when BTN_AUTOREPEAT_EN is defined.
//
// state        | meaning
// IDLE         | released, waiting for btn_s to go high
// PRESS_WAIT   | btn_s high, counting stable cycles before accepting the press
// HELD         | press accepted, btn_level=1
// RELEASE_WAIT | btn_s low, counting stable cycles before accepting the release
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_pulse,
    output logic btn_release
);

    localparam logic [1:0] S_IDLE         = 2'd0;
    localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] S_HELD         = 2'd2;
    localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Catch parameter sets the counters cannot represent at elaboration rather than in silicon.
    if ((DEBOUNCE_CYCLES < 2) ||
        ((64'(DEBOUNCE_CYCLES) >> CNT_W) != 64'd0) ||
        ((64'(REPEAT_DELAY) >> CNT_W) != 64'd0) ||
        ((64'(REPEAT_PERIOD) >> CNT_W) != 64'd0)) begin : g_bad_cfg
        $error("button_conditioner: DEBOUNCE_CYCLES < 2 or a count does not fit in CNT_W");
    end

    logic [1:0]       sync_q;
    logic             btn_s;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic             release_q, release_d;
    logic             rep_pulse;

    assign btn_s = sync_q[1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        pulse_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (btn_s) begin
                    cnt_d   = ONE;
                    state_d = S_PRESS_WAIT;
                end
            end
            S_PRESS_WAIT: begin
                if (!btn_s) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d   = '0;
                    state_d = S_HELD;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_HELD: begin
                if (!btn_s) begin
                    cnt_d   = ONE;
                    state_d = S_RELEASE_WAIT;
                end
            end
            S_RELEASE_WAIT: begin
                if (btn_s) begin
                    cnt_d   = '0;
                    state_d = S_HELD;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
                level_d = 1'b0;
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             rarmed_q, rarmed_d;
    logic             rep_hit;

    // rarmed_q selects the initial delay versus the steady repeat period.
    always_comb begin
        rcnt_d   = rcnt_q;
        rarmed_d = rarmed_q;
        rep_hit  = 1'b0;
        if ((state_q == S_PRESS_WAIT) && (state_d == S_HELD)) begin
            rcnt_d   = '0;
            rarmed_d = 1'b0;
        end else if ((state_q == S_HELD) || (state_q == S_RELEASE_WAIT)) begin
            if (rcnt_q == (rarmed_q ? PER_LAST : DLY_LAST)) begin
                rep_hit  = 1'b1;
                rcnt_d   = '0;
                rarmed_d = 1'b1;
            end else begin
                rcnt_d = rcnt_q + ONE;
            end
        end else begin
            rcnt_d   = '0;
            rarmed_d = 1'b0;
        end
    end

    assign rep_pulse = rep_hit && !release_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rcnt_q   <= '0;
            rarmed_q <= 1'b0;
        end else begin
            rcnt_q   <= rcnt_d;
            rarmed_q <= rarmed_d;
        end
    end
`else
    assign rep_pulse = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= 2'b00;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_in};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d | rep_pulse;
            release_q <= release_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_pulse   = pulse_q;
    assign btn_release = release_q;

endmodule
